// File: rtl/tick_gen_pkg.sv
// Shared types and helpers for the programmable tick generator.
package tick_gen_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int MAX_W = 32;

    typedef logic [DIV_W_DEF-1:0] ratio_t;

    // Rounded-up half of n, one bit wider so n = all-ones cannot overflow.
    function automatic logic [MAX_W:0] half_up(input logic [MAX_W-1:0] n);
        return ({1'b0, n} + 1'b1) >> 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One divide-by-N channel: period counter, active/pending ratio, Tick and Square.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pe,
    input  logic             sync,
    input  logic             load,
    input  logic [DIV_W-1:0] ratio,
    output logic             tick,
    output logic             square,
    output logic             pending
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] pend_ratio;
    logic [DIV_W-1:0] cnt_nx;
    logic [DIV_W-1:0] act_nx;
    logic [DIV_W-1:0] pend_ratio_nx;
    logic             pend_nx;
    logic             tick_nx;
    logic             square_nx;
    logic [DIV_W:0]   half;
    logic             running;
    logic             wrap;

    assign running = (act != '0);
    assign wrap    = (cnt == act - 1'b1);

    always_comb begin
        cnt_nx        = cnt;
        act_nx        = act;
        pend_ratio_nx = pend_ratio;
        pend_nx       = pending;
        tick_nx       = 1'b0;
        if (sync) begin
            cnt_nx  = '0;
            pend_nx = 1'b0;
            if (load) begin
                act_nx = ratio;
            end else if (pending) begin
                act_nx = pend_ratio;
            end
        end else if (!running) begin
            cnt_nx = '0;
            if (load) begin
                act_nx = ratio;
            end
        end else begin
            if (pe) begin
                if (wrap) begin
                    cnt_nx  = '0;
                    tick_nx = 1'b1;
                    if (pending) begin
                        act_nx  = pend_ratio;
                        pend_nx = 1'b0;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            // A new ratio waits for the end of the current period.
            if (load) begin
                pend_ratio_nx = ratio;
                pend_nx       = 1'b1;
            end
        end
        half      = (DIV_W+1)'(half_up(MAX_W'(act_nx)));
        square_nx = (act_nx != '0) && ({1'b0, cnt_nx} < half);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            act        <= '0;
            pend_ratio <= '0;
            pending    <= 1'b0;
            tick       <= 1'b0;
            square     <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            act        <= act_nx;
            pend_ratio <= pend_ratio_nx;
            pending    <= pend_nx;
            tick       <= tick_nx;
            square     <= square_nx;
        end
    end

endmodule

// File: rtl/programmable_tick_generator.sv
// NUM_CH programmable tick channels sharing one prescaler and restart.
module programmable_tick_generator
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int DIV_W    = DIV_W_DEF,
    parameter int PRESCALE = 1
) (
    input  logic                    SysClock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic                    Sync,
    input  logic [NUM_CH*DIV_W-1:0] Ratio,
    input  logic [NUM_CH-1:0]       Load,
    output logic [NUM_CH-1:0]       Tick,
    output logic [NUM_CH-1:0]       Square,
    output logic [NUM_CH-1:0]       Pending
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;
    logic          pe;

    assign pe = Enable && (pcnt == PLAST);

    always_ff @(posedge SysClock or negedge Reset) begin
        if (!Reset) begin
            pcnt <= '0;
        end else if (Sync) begin
            pcnt <= '0;
        end else if (Enable) begin
            pcnt <= (pcnt == PLAST) ? '0 : pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk    (SysClock),
            .rst_n  (Reset),
            .pe     (pe),
            .sync   (Sync),
            .load   (Load[i]),
            .ratio  (Ratio[i*DIV_W +: DIV_W]),
            .tick   (Tick[i]),
            .square (Square[i]),
            .pending(Pending[i])
        );
    end

endmodule

// File: tb/tb_programmable_tick_generator.sv
// Scoreboard bench: two builds (prescale 1 and 4) against a phase-based reference model.
module tb_programmable_tick_generator;

    localparam int NCH = 3;
    localparam int DW  = 4;

    typedef struct packed {
        logic [NCH-1:0] t;
        logic [NCH-1:0] s;
        logic [NCH-1:0] p;
    } out_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              sync;
    logic [NCH*DW-1:0] ratio;
    logic [NCH-1:0]    load;
    logic [NCH-1:0]    tick1, sq1, pd1;
    logic [NCH-1:0]    tick4, sq4, pd4;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: [build][channel]
    int m_pre [2];
    int m_n   [2][NCH];
    int m_ph  [2][NCH];
    int m_pv  [2][NCH];
    bit m_pd  [2][NCH];

    out_t q1[$];
    out_t q4[$];

    always #5 clk = ~clk;

    programmable_tick_generator #(
        .NUM_CH(NCH), .DIV_W(DW), .PRESCALE(1)
    ) dut1 (
        .SysClock(clk), .Reset(rst_n), .Enable(en), .Sync(sync),
        .Ratio(ratio), .Load(load),
        .Tick(tick1), .Square(sq1), .Pending(pd1)
    );

    programmable_tick_generator #(
        .NUM_CH(NCH), .DIV_W(DW), .PRESCALE(4)
    ) dut4 (
        .SysClock(clk), .Reset(rst_n), .Enable(en), .Sync(sync),
        .Ratio(ratio), .Load(load),
        .Tick(tick4), .Square(sq4), .Pending(pd4)
    );

    function automatic int presc(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_pre[k] = 0;
            for (int c = 0; c < NCH; c++) begin
                m_n[k][c]  = 0;
                m_ph[k][c] = 0;
                m_pv[k][c] = 0;
                m_pd[k][c] = 1'b0;
            end
        end
    endtask

    // ph = prescaled steps elapsed in the current period; a period ends when ph reaches N.
    task automatic model_step(input int k, output out_t o);
        bit step;
        bit tk;
        int r;
        o = '0;
        step = en && (m_pre[k] == presc(k) - 1);
        if (sync) m_pre[k] = 0;
        else if (en) m_pre[k] = (m_pre[k] + 1) % presc(k);
        for (int c = 0; c < NCH; c++) begin
            r  = int'(ratio[c*DW +: DW]);
            tk = 1'b0;
            if (sync) begin
                if (load[c]) m_n[k][c] = r;
                else if (m_pd[k][c]) m_n[k][c] = m_pv[k][c];
                m_pd[k][c] = 1'b0;
                m_ph[k][c] = 0;
            end else if (m_n[k][c] == 0) begin
                if (load[c]) m_n[k][c] = r;
                m_ph[k][c] = 0;
            end else begin
                if (step) begin
                    m_ph[k][c]++;
                    if (m_ph[k][c] == m_n[k][c]) begin
                        m_ph[k][c] = 0;
                        tk = 1'b1;
                        if (m_pd[k][c]) begin
                            m_n[k][c]  = m_pv[k][c];
                            m_pd[k][c] = 1'b0;
                        end
                    end
                end
                if (load[c]) begin
                    m_pv[k][c] = r;
                    m_pd[k][c] = 1'b1;
                end
            end
            o.t[c] = tk;
            o.s[c] = (m_n[k][c] != 0) && (m_ph[k][c] < (m_n[k][c] + 1) / 2);
            o.p[c] = m_pd[k][c];
        end
    endtask

    task automatic chk(input string nm, input out_t got, input out_t want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s t=%0t got t/s/p=%b/%b/%b expected %b/%b/%b",
                      nm, $time, got.t, got.s, got.p, want.t, want.s, want.p);
    endtask

    // Model: one expected entry per rising edge.
    initial begin
        out_t o;
        model_clear();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_clear();
                q1.push_back('0);
                q4.push_back('0);
            end else begin
                model_step(0, o);
                q1.push_back(o);
                model_step(1, o);
                q4.push_back(o);
            end
        end
    end

    // Monitor: compare registered outputs on the falling edge.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (q1.size() == 0 || q4.size() == 0) begin
                n_total++;
                $display("FAIL scoreboard_empty t=%0t got size %0d/%0d expected >0",
                         $time, q1.size(), q4.size());
            end else begin
                e = q1.pop_front();
                if (!rst_n) e = '0;
                chk("prescale1", {tick1, sq1, pd1}, e);
                e = q4.pop_front();
                if (!rst_n) e = '0;
                chk("prescale4", {tick4, sq4, pd4}, e);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_p1", {tick1, sq1, pd1}, '0);
        chk("async_reset_p4", {tick4, sq4, pd4}, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic set_ratio(input int c, input int r);
        ratio[c*DW +: DW] = DW'(r);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        sync  = 1'b0;
        load  = '0;
        ratio = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        en = 1'b1;
        cyc(10);
        set_ratio(0, 4); set_ratio(1, 5); set_ratio(2, 1);
        load = 3'b111;
        cyc(1);
        load = '0;
        cyc(40);
        set_ratio(0, 3);
        load = 3'b001;
        cyc(1);
        load = '0;
        cyc(40);
        set_ratio(0, 2); set_ratio(1, 3); set_ratio(2, 6);
        load = 3'b111;
        cyc(1);
        load = '0;
        cyc(33);
        sync = 1'b1;
        cyc(1);
        sync = 1'b0;
        cyc(30);
        en = 1'b0;
        cyc(10);
        en = 1'b1;
        cyc(30);
        set_ratio(1, 15);
        load = 3'b010;
        sync = 1'b1;
        cyc(1);
        load = '0;
        sync = 1'b0;
        cyc(70);
        mid_reset();
        cyc(20);
        set_ratio(0, 2); set_ratio(1, 3); set_ratio(2, 4);
        load = 3'b111;
        cyc(1);
        load = '0;
        cyc(9);
        set_ratio(0, 0);
        load = 3'b001;
        cyc(1);
        load = '0;
        cyc(40);
        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            sync = ($urandom_range(0, 63) == 0);
            for (int c = 0; c < NCH; c++) begin
                load[c] = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 3) == 0) set_ratio(c, int'($urandom_range(0, 15)));
                else set_ratio(c, int'($urandom_range(1, 6)));
            end
            if (i == 1500) mid_reset();
            cyc(1);
        end
        en   = 1'b1;
        sync = 1'b0;
        load = '0;
        cyc(5);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
